// File: rtl/divider_iterative_pkg.sv
// Shared types and constants for the iterative RV32M divider.
// Imported by the interface, the restore-step datapath and the divider top.
package divider_pkg;

  localparam int XLEN      = 32;
  localparam int DIV_ITERS = 32;

  localparam logic [XLEN-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] INT_MIN    = 32'h8000_0000;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } div_state_t;

  // Magnitude of a two's-complement operand; unsigned ops pass through untouched.
  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic signed_op);
    return (signed_op && v[XLEN-1]) ? ({XLEN{1'b0}} - v) : v;
  endfunction

endpackage

// File: rtl/divider_iterative_if.sv
// Request/response bundle between the execute stage and the iterative divider.
interface divider_iterative_if;
  import divider_pkg::*;

  logic            startE;
  logic [1:0]      div_opcode;
  logic [XLEN-1:0] operand1;
  logic [XLEN-1:0] operand2;
  logic [XLEN-1:0] result_divide;
  logic            ready;
  logic            div_use;

  modport master (
    output startE, div_opcode, operand1, operand2,
    input  result_divide, ready, div_use
  );

  modport slave (
    input  startE, div_opcode, operand1, operand2,
    output result_divide, ready, div_use
  );

endinterface

// File: rtl/divider_iterative_restore_step.sv
// One radix-2 restoring step: shift {rem,quo} left, subtract the divisor when it fits.
module div_restore_step
  import divider_pkg::*;
(
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN:0]   shifted_s;
  logic [XLEN+1:0] diff_s;
  logic            unused_s;

  // The shifted remainder needs 33 bits; one more bit holds the borrow of the trial subtract.
  assign shifted_s = {rem, quo[XLEN-1]};
  assign diff_s    = {1'b0, shifted_s} - {2'b00, divisor};
  assign rem_next  = diff_s[XLEN+1] ? shifted_s[XLEN-1:0] : diff_s[XLEN-1:0];
  assign quo_next  = {quo[XLEN-2:0], ~diff_s[XLEN+1]};
  assign unused_s  = ^{shifted_s[XLEN], diff_s[XLEN]};

endmodule

// File: rtl/divider_iterative.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU; one quotient bit per cycle.
// Divide-by-zero and signed overflow finish in a single cycle without iterating.
module divider_iterative
  import divider_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  divider_iterative_if.slave dif
);

  localparam int CNT_W = 5;

  div_state_t       state_r;
  div_state_t       state_nxt_s;
  div_op_t          op_r;
  logic [CNT_W-1:0] cnt_r;
  logic [XLEN-1:0]  rem_r;
  logic [XLEN-1:0]  quo_r;
  logic [XLEN-1:0]  divisor_r;
  logic [XLEN-1:0]  result_r;
  logic             q_neg_r;
  logic             r_neg_r;
  logic             ready_r;

  logic             signed_s;
  logic             zero_s;
  logic             ovf_s;
  logic             special_s;
  logic             accept_s;
  logic             busy_s;
  logic [XLEN-1:0]  special_res_s;
  logic [XLEN-1:0]  rem_nxt_s;
  logic [XLEN-1:0]  quo_nxt_s;
  logic [XLEN-1:0]  quo_fix_s;
  logic [XLEN-1:0]  rem_fix_s;

  assign signed_s  = ~dif.div_opcode[0];
  assign zero_s    = (dif.operand2 == {XLEN{1'b0}});
  assign ovf_s     = signed_s && (dif.operand1 == INT_MIN) && (dif.operand2 == {XLEN{1'b1}});
  assign special_s = zero_s | ovf_s;

  // Result for the requests that bypass iteration; bit 1 of the opcode selects remainder.
  always_comb begin
    special_res_s = {XLEN{1'b0}};
    if (zero_s) begin
      special_res_s = dif.div_opcode[1] ? dif.operand1 : DIV_ZERO_Q;
    end else begin
      special_res_s = dif.div_opcode[1] ? {XLEN{1'b0}} : INT_MIN;
    end
  end

  div_restore_step u_step (
    .rem      (rem_r),
    .quo      (quo_r),
    .divisor  (divisor_r),
    .rem_next (rem_nxt_s),
    .quo_next (quo_nxt_s)
  );

  assign quo_fix_s = q_neg_r ? ({XLEN{1'b0}} - quo_r) : quo_r;
  assign rem_fix_s = r_neg_r ? ({XLEN{1'b0}} - rem_r) : rem_r;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; a new request is only taken while idle or finishing.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    busy_s      = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (dif.startE) begin
          accept_s    = 1'b1;
          state_nxt_s = special_s ? DONE : CALC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC: begin
        busy_s = 1'b1;
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_nxt_s = FIX;
        end else begin
          state_nxt_s = CALC;
        end
      end
      FIX: begin
        busy_s      = 1'b1;
        state_nxt_s = DONE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Stall is combinational so the upstream registers freeze in the accept cycle itself.
  assign dif.div_use       = busy_s | (accept_s & ~special_s);
  assign dif.ready         = ready_r;
  assign dif.result_divide = result_r;

  // Operand latch, iteration and sign fix-up; result_r only moves on entry to DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_r      <= DIV;
      cnt_r     <= {CNT_W{1'b0}};
      rem_r     <= {XLEN{1'b0}};
      quo_r     <= {XLEN{1'b0}};
      divisor_r <= {XLEN{1'b0}};
      result_r  <= {XLEN{1'b0}};
      q_neg_r   <= 1'b0;
      r_neg_r   <= 1'b0;
      ready_r   <= 1'b0;
    end else begin
      ready_r <= (state_nxt_s == DONE);
      if (accept_s) begin
        op_r      <= div_op_t'(dif.div_opcode);
        q_neg_r   <= signed_s & (dif.operand1[XLEN-1] ^ dif.operand2[XLEN-1]);
        r_neg_r   <= signed_s & dif.operand1[XLEN-1];
        divisor_r <= abs_val(dif.operand2, signed_s);
        quo_r     <= abs_val(dif.operand1, signed_s);
        rem_r     <= {XLEN{1'b0}};
        cnt_r     <= CNT_W'(DIV_ITERS - 1);
        if (special_s) begin
          result_r <= special_res_s;
        end
      end else if (state_r == CALC) begin
        rem_r <= rem_nxt_s;
        quo_r <= quo_nxt_s;
        cnt_r <= cnt_r - CNT_W'(1);
      end else if (state_r == FIX) begin
        result_r <= ((op_r == REM) || (op_r == REMU)) ? rem_fix_s : quo_fix_s;
      end
    end
  end

endmodule

// File: doc/divider_iterative.md
# divider_iterative

Multi-cycle radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions. It sits in the execute stage beside `multiplier_iterative`. It takes `operand1`/`operand2`/`div_opcode` from the M-extension operand check and returns `result_divide` with a `ready` pulse. While it is busy it raises `div_use`, which stalls the PC and the upstream pipeline registers in the same way `mul_use` does. It replaces the combinational 32-bit divider so that the divide no longer sits in the execute-stage critical path.

## Interface
- `XLEN`, 32, operand and result width (only 32 is supported)
- `clk`  input  1  single clock; all state updates on the rising edge
- `rst`  input  1  reset, asynchronous, active-low
- `startE`  input  1  divide request from the execute-stage register; sampled when idle
- `div_opcode`  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- `operand1`  input  XLEN  dividend
- `operand2`  input  XLEN  divisor
- `result_divide`  output  XLEN  quotient or remainder, registered, held until the next accepted request
- `ready`  output  1  one-cycle pulse; `result_divide` is valid in that cycle
- `div_use`  output  1  stall request to the PC and pipeline registers

## Operation
- States: IDLE, CALC, FIX, DONE (state enum lives in the package).
- **Accept:** in IDLE or DONE, `startE`=1 at a rising edge latches the following:
  - `|dividend|` and `|divisor|` (absolute values only for signed ops);
  - quotient sign = `op1[31]^op2[31]` (signed only);
  - remainder sign = `op1[31]` (signed only);
  - the opcode.
  - Remainder accumulator is cleared and the 5-bit counter is set to 31.
- **Special cases, decided at accept:** these go straight to DONE with the result registered, with no CALC/FIX.
  - Divisor = 0: quotient = 0xFFFFFFFF; remainder = operand1.
  - Signed overflow (op1 = 0x80000000, op2 = 0xFFFFFFFF, DIV/REM): quotient = 0x80000000; remainder = 0.
- **CALC:** one restoring step per cycle.
  - `{rem,quo} <<= 1`.
  - If `rem >= divisor` then subtract, `quo[0] = 1`.
  - Remainder path is 33 bits wide. Counter decrements; at counter 0 go to FIX.
- **FIX:**
  - Negate the quotient if its sign bit is set (signed ops only).
  - Negate the remainder if its sign bit is set (signed ops only).
  - Select quotient (DIV/DIVU) or remainder (REM/REMU) into `result_divide`, then go to DONE.
- **DONE:**
  - `ready` = 1.
  - Without `startE`, go to IDLE.
  - With `startE`, accept the new request (back-to-back).
- `startE` during CALC or FIX is ignored; the upstream stall guarantees it is held.
- `div_use` = (state ∈ {CALC, FIX}) | (state ∈ {IDLE, DONE} & `startE` & not special case). It is combinational, so the stall takes effect in the accept cycle.
- **Reset** (any time, including mid-CALC): all of the following are zero, and the in-flight operation is discarded:
  - state = IDLE;
  - `result_divide` = 0;
  - `ready` = 0;
  - `div_use` = 0 once `startE` is low;
  - counter and accumulators.

## Timing
- Cycle 0 is when `startE` is sampled.
- Normal path:
  - cycles 1–32: CALC;
  - cycle 33: FIX;
  - cycle 34: DONE, `ready` = 1.
  - Latency is 34 cycles. `div_use` is high in cycles 0–33 and low in cycle 34, so the instruction advances with its result.
- Special path: DONE in cycle 1, `ready` in cycle 1, `div_use` low throughout.
- `ready` is never high for more than one consecutive cycle unless back-to-back special-case requests arrive.
- `result_divide` changes only on the edge entering DONE, or on reset.

## Structure
- Package `divider_pkg` holds:
  - `XLEN`;
  - `div_op_t` enum: DIV=2'b00, DIVU=2'b01, REM=2'b10, REMU=2'b11;
  - `div_state_t` enum;
  - constants `DIV_ITERS`=32, `DIV_ZERO_Q`=32'hFFFFFFFF, `INT_MIN`=32'h80000000.
- One natural sub-module, `div_restore_step`: a combinational single-bit shift/compare/subtract taking `{rem,quo,divisor}` and returning the next `{rem,quo}`.
- FSM, counter, sign handling and result registers stay in `divider_iterative`. Target size is about 200 lines.

## Test plan
- DIVU 100 / 7 → `result_divide` = 14, `ready` in cycle 34, `div_use` high in cycles 0–33.
- REM −7 (0xFFFFFFF9) / 2 → 0xFFFFFFFF (−1); DIV of the same operands → 0xFFFFFFFD (−3).
- DIV by 0: op1 = 0x12345678 → 0xFFFFFFFF. REMU by 0 → 0x12345678. Both give `ready` in cycle 1 and `div_use` never high.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same operands → 0; both with `ready` in cycle 1.
- Back-to-back: `startE` asserted in the DONE cycle with DIVU 0xFFFFFFFF / 1 → the first result is held through DONE, and the second result is 0xFFFFFFFF exactly 34 cycles later.
- `rst` driven low at cycle 15 of a CALC → `result_divide` = 0, `ready` = 0, state IDLE, asynchronously (before the next edge). A fresh DIVU 9 / 3 afterwards gives 3.
